sync_fifo_param: RTL and testbench
==================================

Name: sync_fifo_param

Overview:
Single-clock FIFO with parametrised data width and depth, built on an internal simple dual-port memory.
- Provides full, empty and almost_full/almost_empty flags, an occupancy count, and sticky overflow/underflow error flags.
- Provides a selectable first-word-fall-through (FWFT) read mode.
- Used as the general line/burst buffer between ISP pipeline stages and the SDRAM controller datapath where both sides share one clock.

Parameters:
DATA_W, 16, data word width in bits (>=1)
ADDR_W, 4, address width; depth DEPTH = 2**ADDR_W words (ADDR_W >= 1)
FWFT, 0, 0 = standard registered read (latency 1); 1 = first-word-fall-through
AF_LEVEL, 2**ADDR_W-2, almost_full asserted when count >= AF_LEVEL
AE_LEVEL, 2, almost_empty asserted when count <= AE_LEVEL

Ports:
clk  in  1  single clock for all logic; rising edge
rst  in  1  reset, synchronous, active-low (sampled on rising clk; 0 = reset)
w_en  in  1  write request
data_in  in  DATA_W  write data, sampled with w_en
r_en  in  1  read request (standard mode) / pop (FWFT mode)
data_out  out  DATA_W  read data
data_valid  out  1  data_out holds a valid word (see Behaviour)
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_LEVEL
almost_empty  out  1  count <= AE_LEVEL
count  out  ADDR_W+1  current occupancy, 0..DEPTH
overflow  out  1  sticky: a write was attempted while full
underflow  out  1  sticky: a read was attempted while empty

Behaviour:
- Reset (rst==0 at clk edge):
  - wr_ptr, rd_ptr and count clear to 0; empty=1, full=0, almost_empty=1, almost_full=0 (with default levels).
  - data_out=0, data_valid=0, overflow=0, underflow=0.
  - Memory array is not cleared.
  - Reset mid-operation discards all contents; in-flight reads are dropped.
- Write accepted: wr_acc = w_en & ~full.
  - mem[wr_ptr] <= data_in; wr_ptr increments, wrapping modulo DEPTH.
  - When the write is not accepted, memory is left untouched; no zero-writes.
- Read accepted: rd_acc = r_en & ~empty.
  - rd_ptr increments, wrapping modulo DEPTH.
- Count update: +1 on wr_acc only, -1 on rd_acc only, unchanged if both or neither.
  - All flags are registered, derived from next-count, and valid the cycle after the causing edge.
- Simultaneous events:
  - Full with w_en&r_en: write rejected, read accepted, count -1, overflow set.
  - Empty with w_en&r_en: write accepted, read rejected, count +1, underflow set.
  - Neither full nor empty with w_en&r_en: both accepted, count unchanged.
- Standard mode (FWFT=0):
  - On rd_acc, data_out <= mem[rd_ptr] at that edge; data_valid=1 for exactly the following cycle.
  - Otherwise data_valid=0 and data_out holds its last value (not zeroed).
  - Read latency is 1 cycle.
- FWFT mode (FWFT=1):
  - data_out = mem[rd_ptr] continuously; data_valid = ~empty.
  - r_en acts as an acknowledge/pop of the displayed word.
  - The first word written into an empty FIFO appears with data_valid=1 one cycle after its write edge.
- Sticky flags:
  - overflow <= 1 on w_en&full; underflow <= 1 on r_en&empty.
  - Both clear only by reset.
- Parameter checks: AF_LEVEL in 1..DEPTH and AE_LEVEL in 0..DEPTH-1. Violations are flagged by a simulation-time $error in an initial block.

Decomposition:
- Shared package fifo_pkg:
  - function clog2;
  - localparam-style constants for mode encoding FIFO_MODE_STD=0 and FIFO_MODE_FWFT=1.
- One sub-module: sdp_ram (simple dual-port, one clock, write port plus async-read port). sync_fifo_param wraps it with the pointer/count/flag control and the mode-dependent output stage.

Test Plan:
- DATA_W=8, ADDR_W=2, FWFT=0: reset, write 0x11,0x22,0x33,0x44 on consecutive cycles -> full=1 and count=4 after the 4th edge, almost_full=1 from count=2; fifth write 0x55 -> overflow=1, contents unchanged.
- Same config, read 4 times -> data_out 0x11,0x22,0x33,0x44 each with data_valid=1 one cycle after its r_en; empty=1 after the last; fifth r_en -> underflow=1, data_out holds 0x44, data_valid=0.
- Wrap-around: ADDR_W=2, 10 interleaved write/read pairs with incrementing data 0..9 -> reads return 0..9 in order, count stays within 0..1, no error flags.
- Simultaneous events:
  - FIFO full with w_en=r_en=1 -> count 4->3, overflow=1, oldest word popped.
  - FIFO empty with w_en=r_en=1, data 0xA5 -> count 0->1, underflow=1.
  - Half full with w_en=r_en=1 -> count unchanged.
- FWFT=1: write 0x3C into empty FIFO -> next cycle data_out=0x3C, data_valid=1 without r_en; r_en pulse -> empty=1, data_valid=0 the next cycle.
- Reset mid-stream: 3 words stored, rst=0 for one edge -> count=0, empty=1, flags cleared; a subsequent write/read returns only the new word.

Source files
------------

// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared constants and helpers for the sync FIFO slice
package fifo_pkg;

  localparam int FIFO_MODE_STD  = 0;
  localparam int FIFO_MODE_FWFT = 1;

  function automatic int clog2(input int value);
    int res;
    res = 0;
    while ((1 << res) < value) begin
      res = res + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/sync_fifo_param_if.sv
// rtl/sync_fifo_param_if.sv - producer/consumer signal bundle for sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
);

  logic              w_en;
  logic [DATA_W-1:0] data_in;
  logic              r_en;
  logic [DATA_W-1:0] data_out;
  logic              data_valid;
  logic              full;
  logic              empty;
  logic              almost_full;
  logic              almost_empty;
  logic [ADDR_W:0]   count;
  logic              overflow;
  logic              underflow;

  modport master (
    output w_en, data_in, r_en,
    input  data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

  modport slave (
    input  w_en, data_in, r_en,
    output data_out, data_valid, full, empty, almost_full, almost_empty,
           count, overflow, underflow
  );

endinterface

// File: rtl/sync_fifo_param_sdp_ram.sv
// rtl/sync_fifo_param_sdp_ram.sv - simple dual-port RAM, clocked write, asynchronous read
module sdp_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - single-clock FIFO with registered flags and selectable FWFT output
module sync_fifo_param
  import fifo_pkg::*;
#(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int FWFT     = FIFO_MODE_STD,
  parameter int AF_LEVEL = 2**ADDR_W - 2,
  parameter int AE_LEVEL = 2
) (
  input  logic clk,
  input  logic rst,
  sync_fifo_param_if.slave bus
);

  localparam int DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0] AF_C    = (ADDR_W+1)'(AF_LEVEL);
  localparam logic [ADDR_W:0] AE_C    = (ADDR_W+1)'(AE_LEVEL);

  initial begin
    if (AF_LEVEL < 1 || AF_LEVEL > DEPTH) begin
      $error("sync_fifo_param: AF_LEVEL %0d outside 1..%0d", AF_LEVEL, DEPTH);
    end
    if (AE_LEVEL < 0 || AE_LEVEL > DEPTH - 1) begin
      $error("sync_fifo_param: AE_LEVEL %0d outside 0..%0d", AE_LEVEL, DEPTH - 1);
    end
  end

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count_q;
  logic [ADDR_W:0]   count_nxt;
  logic              full_q;
  logic              empty_q;
  logic              almost_full_q;
  logic              almost_empty_q;
  logic              overflow_q;
  logic              underflow_q;
  logic              wr_acc;
  logic              rd_acc;
  logic [DATA_W-1:0] rd_data;

  // Acceptance uses the registered flags, so a full FIFO still pops and an empty one still pushes.
  assign wr_acc = bus.w_en & ~full_q;
  assign rd_acc = bus.r_en & ~empty_q;

  always_comb begin
    count_nxt = count_q;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count_q + (ADDR_W+1)'(1);
      2'b01:   count_nxt = count_q - (ADDR_W+1)'(1);
      default: count_nxt = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count_q        <= '0;
      full_q         <= 1'b0;
      empty_q        <= 1'b1;
      almost_full_q  <= 1'b0;
      almost_empty_q <= 1'b1;
      overflow_q     <= 1'b0;
      underflow_q    <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count_q        <= count_nxt;
      full_q         <= (count_nxt == DEPTH_C);
      empty_q        <= (count_nxt == '0);
      almost_full_q  <= (count_nxt >= AF_C);
      almost_empty_q <= (count_nxt <= AE_C);
      overflow_q     <= overflow_q  | (bus.w_en & full_q);
      underflow_q    <= underflow_q | (bus.r_en & empty_q);
    end
  end

  sdp_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (bus.data_in),
    .raddr (rd_ptr),
    .rdata (rd_data)
  );

  generate
    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
      // Head word is shown directly; masked to zero while empty so reset leaves data_out at 0.
      assign bus.data_out   = empty_q ? '0 : rd_data;
      assign bus.data_valid = ~empty_q;
    end else begin : g_std
      logic [DATA_W-1:0] data_out_q;
      logic              data_valid_q;

      always_ff @(posedge clk) begin
        if (!rst) begin
          data_out_q   <= '0;
          data_valid_q <= 1'b0;
        end else begin
          data_valid_q <= rd_acc;
          if (rd_acc) begin
            data_out_q <= rd_data;
          end
        end
      end

      assign bus.data_out   = data_out_q;
      assign bus.data_valid = data_valid_q;
    end
  endgenerate

  assign bus.count        = count_q;
  assign bus.full         = full_q;
  assign bus.empty        = empty_q;
  assign bus.almost_full  = almost_full_q;
  assign bus.almost_empty = almost_empty_q;
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - randomized and directed bench for sync_fifo_param in both read modes
module tb_sync_fifo_param;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF    = 2;
  localparam int AE    = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;

  always #5 clk = ~clk;

  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) s_if ();
  sync_fifo_param_if #(.DATA_W(DW), .ADDR_W(AW)) f_if ();

  sync_fifo_param #(
    .DATA_W(DW), .ADDR_W(AW), .FWFT(0), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_std (
    .clk (clk),
    .rst (rst),
    .bus (s_if.slave)
  );

  sync_fifo_param #(
    .DATA_W(DW), .ADDR_W(AW), .FWFT(1), .AF_LEVEL(AF), .AE_LEVEL(AE)
  ) u_fwft (
    .clk (clk),
    .rst (rst),
    .bus (f_if.slave)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: a queue holding the FIFO contents plus the sticky flags and last std-mode read.
  logic [DW-1:0] q[$];
  logic          m_ovf;
  logic          m_unf;
  logic [DW-1:0] m_sdout;
  logic          m_svalid;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_flags(input string who, input logic [AW:0] cnt, input logic full,
                             input logic empty, input logic af, input logic ae,
                             input logic ovf, input logic unf);
    int n;
    n = q.size();
    check_val({who, ".count"}, 32'(cnt), 32'(n));
    check_val({who, ".full"}, 32'(full), 32'(n == DEPTH));
    check_val({who, ".empty"}, 32'(empty), 32'(n == 0));
    check_val({who, ".almost_full"}, 32'(af), 32'(n >= AF));
    check_val({who, ".almost_empty"}, 32'(ae), 32'(n <= AE));
    check_val({who, ".overflow"}, 32'(ovf), 32'(m_ovf));
    check_val({who, ".underflow"}, 32'(unf), 32'(m_unf));
  endtask

  task automatic check_all();
    logic [DW-1:0] head;
    head = (q.size() > 0) ? q[0] : '0;
    check_flags("std", s_if.count, s_if.full, s_if.empty, s_if.almost_full,
                s_if.almost_empty, s_if.overflow, s_if.underflow);
    check_val("std.data_valid", 32'(s_if.data_valid), 32'(m_svalid));
    check_val("std.data_out", 32'(s_if.data_out), 32'(m_sdout));
    check_flags("fwft", f_if.count, f_if.full, f_if.empty, f_if.almost_full,
                f_if.almost_empty, f_if.overflow, f_if.underflow);
    check_val("fwft.data_valid", 32'(f_if.data_valid), 32'(q.size() > 0));
    check_val("fwft.data_out", 32'(f_if.data_out), 32'(head));
  endtask

  task automatic drive(input logic w, input logic [DW-1:0] d, input logic r);
    s_if.w_en = w;  s_if.data_in = d;  s_if.r_en = r;
    f_if.w_en = w;  f_if.data_in = d;  f_if.r_en = r;
  endtask

  task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
    logic wa;
    logic ra;
    drive(w, d, r);
    @(posedge clk);
    wa = w && (q.size() < DEPTH);
    ra = r && (q.size() > 0);
    if (w && q.size() == DEPTH) m_ovf = 1'b1;
    if (r && q.size() == 0)     m_unf = 1'b1;
    m_svalid = ra;
    if (ra) m_sdout = q.pop_front();
    if (wa) q.push_back(d);
    #1;
    check_all();
    drive(1'b0, '0, 1'b0);
  endtask

  task automatic do_reset();
    drive(1'b0, '0, 1'b0);
    rst = 1'b0;
    @(posedge clk);
    q.delete();
    m_ovf    = 1'b0;
    m_unf    = 1'b0;
    m_sdout  = '0;
    m_svalid = 1'b0;
    #1;
    rst = 1'b1;
    check_all();
  endtask

  initial begin
    int wp;
    drive(1'b0, '0, 1'b0);
    do_reset();

    // Fill to full, then overflow attempt.
    step(1'b1, 8'h11, 1'b0);
    step(1'b1, 8'h22, 1'b0);
    step(1'b1, 8'h33, 1'b0);
    step(1'b1, 8'h44, 1'b0);
    step(1'b1, 8'h55, 1'b0);
    // Drain, then underflow attempt.
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Wrap-around with interleaved write/read pairs.
    do_reset();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 8'(i), 1'b0);
      step(1'b0, '0, 1'b1);
    end

    // Simultaneous write and read while full.
    do_reset();
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'hA0 + i), 1'b0);
    step(1'b1, 8'hEE, 1'b1);

    // Simultaneous write and read while empty.
    do_reset();
    step(1'b1, 8'hA5, 1'b1);
    step(1'b0, '0, 1'b1);

    // Simultaneous write and read while half full.
    do_reset();
    step(1'b1, 8'h01, 1'b0);
    step(1'b1, 8'h02, 1'b0);
    step(1'b1, 8'h03, 1'b1);
    step(1'b1, 8'h04, 1'b1);

    // FWFT fall-through of a single word and its pop.
    do_reset();
    step(1'b1, 8'h3C, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Reset in the middle of a stream discards stored words.
    do_reset();
    step(1'b1, 8'h71, 1'b0);
    step(1'b1, 8'h72, 1'b0);
    step(1'b1, 8'h73, 1'b0);
    do_reset();
    step(1'b1, 8'h99, 1'b0);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // Randomized traffic with write-heavy, balanced and read-heavy phases.
    do_reset();
    for (int i = 0; i < 600; i++) begin
      case ((i / 50) % 3)
        0:       wp = 75;
        1:       wp = 50;
        default: wp = 25;
      endcase
      if ($urandom_range(0, 249) == 0) begin
        do_reset();
      end else begin
        step($urandom_range(0, 99) < wp, 8'($urandom), $urandom_range(0, 99) < (100 - wp));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
